// File: rtl/integer_divider_unit.sv
// Multi-cycle restoring radix-2 integer divider with valid/ready handshakes.
// Signed or unsigned operands. Returns either the quotient or the remainder.
// The word width comes from TIA_WORD_WIDTH, which is normally supplied by datapath.svh.
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

module integer_divider_unit (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic                       is_signed,
  input  logic                       want_remainder,
  input  logic [`TIA_WORD_WIDTH-1:0] dividend,
  input  logic [`TIA_WORD_WIDTH-1:0] divisor,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic [`TIA_WORD_WIDTH-1:0] result,
  output logic                       divide_by_zero
);

  localparam int unsigned W = `TIA_WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    FIXUP,
    DONE
  } state_t;

  state_t         r_state;
  logic [5:0]     r_count;
  logic [W-1:0]   r_quo;       // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]   r_div;       // divisor magnitude
  logic [W:0]     r_rem;       // partial remainder, one bit wider than the word
  logic           r_q_neg;
  logic           r_r_neg;
  logic           r_want_rem;
  logic           r_input_ready;
  logic           r_output_valid;
  logic [W-1:0]   r_result;
  logic           r_dbz;

  logic [W-1:0]   w_abs_dvd;
  logic [W-1:0]   w_abs_dvs;
  logic [W+1:0]   w_diff;
  logic           w_fits;
  logic [W-1:0]   w_quo_fix;
  logic [W-1:0]   w_rem_fix;

  // Operand magnitudes, trial subtraction for one restoring step, and sign fixup
  always_comb begin
    w_abs_dvd = (is_signed && dividend[W-1]) ? -dividend : dividend;
    w_abs_dvs = (is_signed && divisor[W-1])  ? -divisor  : divisor;
    // The shifted remainder is at most W+1 bits. The extra top bit of w_diff
    // acts as the borrow flag: if it is set, the divisor did not fit.
    w_diff    = {1'b0, r_rem[W-1:0], r_quo[W-1]} - {2'b00, r_div};
    w_fits    = ~w_diff[W+1] & ~r_rem[W];
    w_quo_fix = r_q_neg ? -r_quo : r_quo;
    w_rem_fix = r_r_neg ? -r_rem[W-1:0] : r_rem[W-1:0];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_rem          <= '0;
      r_q_neg        <= 1'b0;
      r_r_neg        <= 1'b0;
      r_want_rem     <= 1'b0;
      r_input_ready  <= 1'b1;
      r_output_valid <= 1'b0;
      r_result       <= '0;
      r_dbz          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (input_valid) begin
            r_want_rem    <= want_remainder;
            r_input_ready <= 1'b0;
            if (divisor == '0) begin
              r_result       <= want_remainder ? dividend : '1;
              r_dbz          <= 1'b1;
              r_output_valid <= 1'b1;
              r_state        <= DONE;
            end else begin
              r_quo   <= w_abs_dvd;
              r_div   <= w_abs_dvs;
              r_rem   <= '0;
              r_count <= '0;
              r_q_neg <= is_signed & (dividend[W-1] ^ divisor[W-1]);
              r_r_neg <= is_signed & dividend[W-1];
              r_dbz   <= 1'b0;
              r_state <= ITERATE;
            end
          end
        end
        ITERATE: begin
          r_rem   <= w_fits ? w_diff[W:0] : {r_rem[W-1:0], r_quo[W-1]};
          r_quo   <= {r_quo[W-2:0], w_fits};
          r_count <= r_count + 6'd1;
          if (r_count == 6'(W - 1)) begin
            r_state <= FIXUP;
          end
        end
        FIXUP: begin
          r_result       <= r_want_rem ? w_rem_fix : w_quo_fix;
          r_output_valid <= 1'b1;
          r_state        <= DONE;
        end
        DONE: begin
          if (output_ready) begin
            r_output_valid <= 1'b0;
            r_input_ready  <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign input_ready    = r_input_ready;
  assign output_valid   = r_output_valid;
  assign result         = r_result;
  assign divide_by_zero = r_dbz;

endmodule

// File: tb/tb_integer_divider_unit.sv
// Directed and random checks of integer_divider_unit, using a scoreboard queue.
module tb_integer_divider_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic        is_signed;
  logic        want_remainder;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        output_valid;
  logic        output_ready;
  logic [31:0] result;
  logic        divide_by_zero;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  integer_divider_unit dut (
    .clock          (clock),
    .reset          (reset),
    .input_valid    (input_valid),
    .input_ready    (input_ready),
    .is_signed      (is_signed),
    .want_remainder (want_remainder),
    .dividend       (dividend),
    .divisor        (divisor),
    .output_valid   (output_valid),
    .output_ready   (output_ready),
    .result         (result),
    .divide_by_zero (divide_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input bit sgn, input bit wrem,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return wrem ? r : q;
  endfunction

  task automatic run_op(input bit sgn, input bit wrem, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input string tag);
    exp_t e;
    int   lat;
    @(negedge clock);
    chk({tag, "_ready"}, {31'd0, input_ready}, 32'd1);
    is_signed      = sgn;
    want_remainder = wrem;
    dividend       = a;
    divisor        = b;
    input_valid    = 1'b1;
    output_ready   = 1'b0;
    sb.push_back('{res: model(sgn, wrem, a, b), dbz: (b == 32'd0), lat: (b == 32'd0) ? 1 : 34});
    @(posedge clock);
    #1;
    input_valid    = 1'b0;
    is_signed      = ~sgn;
    want_remainder = ~wrem;
    dividend       = $urandom;
    divisor        = $urandom;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!output_valid && lat < 100);
    e = sb.pop_front();
    chk({tag, "_valid"}, {31'd0, output_valid}, 32'd1);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_dbz"}, {31'd0, divide_by_zero}, {31'd0, e.dbz});
    repeat (hold) begin
      @(negedge clock);
      chk({tag, "_hold_result"}, result, e.res);
      chk({tag, "_hold_ready"}, {31'd0, input_ready}, 32'd0);
    end
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    output_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_valid_drop"}, {31'd0, output_valid}, 32'd0);
  endtask

  initial begin
    bit seen;
    reset          = 1'b1;
    input_valid    = 1'b0;
    output_ready   = 1'b0;
    is_signed      = 1'b0;
    want_remainder = 1'b0;
    dividend       = '0;
    divisor        = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", {31'd0, input_ready}, 32'd1);
    chk("rst_valid", {31'd0, output_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dbz", {31'd0, divide_by_zero}, 32'd0);

    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0, "u100div7_q");
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, "u100div7_r");
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, "sm7div2_q");
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "sm7div2_r");
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, "ubigdiv2_q");
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "ubigdiv2_r");
    run_op(1'b0, 1'b0, 32'h1234, 32'd0, 0, "dbz_u_q");
    run_op(1'b1, 1'b0, 32'h1234, 32'd0, 0, "dbz_s_q");
    run_op(1'b0, 1'b1, 32'h1234, 32'd0, 0, "dbz_r");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf_q");
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf_r");
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0, "s7divm2_q");
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, "sm7divm2_r");
    run_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd1000, 10, "hold");
    chk("hold_ready_after", {31'd0, input_ready}, 32'd1);

    // Abort an operation while it is iterating.
    @(negedge clock);
    is_signed      = 1'b0;
    want_remainder = 1'b0;
    dividend       = 32'd50;
    divisor        = 32'd5;
    input_valid    = 1'b1;
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (output_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    chk("abort_ready", {31'd0, input_ready}, 32'd1);
    run_op(1'b0, 1'b0, 32'd9, 32'd3, 0, "post_abort_q");

    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             (i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom, 0, "rand");
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
